// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus data-memory access engine: captures execute results,
// runs byte/half/word loads and stores over a req/ack handshake and stalls upstream meanwhile.
module mem_access_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [6:0]  ctrl_signal_i,
    input  logic [31:0] retAlu_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  WriReg_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [6:0]  ctrl_signal_o,
    output logic [31:0] Readdata_o,
    output logic [31:0] retAlu_o,
    output logic [4:0]  WriReg_o
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_r;
    logic        valid_r;
    logic [6:0]  ctrl_r;
    logic [31:0] alu_r;
    logic [31:0] wdata_r;
    logic [4:0]  wreg_r;
    logic        misalign_r;

    logic        in_valid_s;
    logic        in_mem_s;
    logic        in_mis_s;
    logic        stall_s;
    logic        req_s;
    logic        store_s;
    logic        load_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            default: return (addr != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
        case (size)
            2'b00:   return 4'b0001 << addr;
            2'b01:   return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Lane select then sign/zero extension of the returned word
    function automatic logic [31:0] load_format(input logic [1:0] size, input logic uns,
                                                input logic [1:0] addr, input logic [31:0] rd);
        logic [31:0] lane;
        logic [15:0] half;
        lane = rd >> {addr, 3'b000};
        half = addr[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   return {{24{~uns & lane[7]}}, lane[7:0]};
            2'b01:   return {{16{~uns & half[15]}}, half};
            default: return rd;
        endcase
    endfunction

    assign in_valid_s = valid_i & ~flush_i;
    assign in_mem_s   = in_valid_s & (ctrl_signal_i[3] | ctrl_signal_i[2]);
    assign in_mis_s   = in_mem_s & is_misaligned(ctrl_signal_i[6:5], retAlu_i[1:0]);

    assign req_s   = (state_r == WAIT);
    assign stall_s = req_s & ~dmem_ack_i;
    assign store_s = ctrl_r[2];
    assign load_s  = valid_r & ctrl_r[3] & ~ctrl_r[2];

    // Entry capture, misalign pulse and access FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            valid_r    <= 1'b0;
            ctrl_r     <= 7'd0;
            alu_r      <= 32'd0;
            wdata_r    <= 32'd0;
            wreg_r     <= 5'd0;
            misalign_r <= 1'b0;
        end else if (!stall_s) begin
            // Killed misaligned ops enter as bubbles so they never reach the memory
            if (in_valid_s && !in_mis_s) begin
                valid_r <= 1'b1;
                ctrl_r  <= ctrl_signal_i;
                alu_r   <= retAlu_i;
                wdata_r <= wdata_i;
                wreg_r  <= WriReg_i;
            end else begin
                valid_r <= 1'b0;
                ctrl_r  <= 7'd0;
                alu_r   <= 32'd0;
                wdata_r <= 32'd0;
                wreg_r  <= 5'd0;
            end
            misalign_r <= in_mis_s;
            state_r    <= (in_mem_s && !in_mis_s) ? WAIT : IDLE;
        end else begin
            misalign_r <= 1'b0;
        end
    end

    assign stall_o      = stall_s;
    assign misalign_o   = misalign_r;
    assign dmem_req_o   = req_s;
    assign dmem_we_o    = req_s & store_s;
    assign dmem_addr_o  = req_s ? {alu_r[31:2], 2'b00} : 32'd0;
    assign dmem_be_o    = req_s ? byte_en(ctrl_r[6:5], alu_r[1:0]) : 4'd0;
    assign dmem_wdata_o = (req_s && store_s) ? store_data(ctrl_r[6:5], wdata_r) : 32'd0;

    assign ctrl_signal_o = stall_s ? 7'd0 : ctrl_r;
    assign Readdata_o    = load_s ? load_format(ctrl_r[6:5], ctrl_r[4], alu_r[1:0], dmem_rdata_i)
                                  : 32'd0;
    assign retAlu_o      = alu_r;
    assign WriReg_o      = wreg_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results are queued at issue
// and compared when the stage presents them; handshake outputs are checked per cycle.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, flush_i, dmem_ack_i;
    logic [6:0]  ctrl_signal_i;
    logic [31:0] retAlu_i, wdata_i, dmem_rdata_i;
    logic [4:0]  WriReg_i;
    logic        stall_o, misalign_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, Readdata_o, retAlu_o;
    logic [3:0]  dmem_be_o;
    logic [6:0]  ctrl_signal_o;
    logic [4:0]  WriReg_o;

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wreg;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    mem_access_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ctrl_signal_i(ctrl_signal_i),
        .retAlu_i(retAlu_i), .wdata_i(wdata_i), .WriReg_i(WriReg_i), .flush_i(flush_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .ctrl_signal_o(ctrl_signal_o), .Readdata_o(Readdata_o), .retAlu_o(retAlu_o),
        .WriReg_o(WriReg_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pop the oldest expected result and compare it with what MEM/WB would capture
    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, "_sbq"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_ctrl"}, 32'(ctrl_signal_o), 32'(e.ctrl));
            check({tag, "_rd"},   Readdata_o, e.rd);
            check({tag, "_alu"},  retAlu_o, e.alu);
            check({tag, "_wreg"}, 32'(WriReg_o), 32'(e.wreg));
        end
    endtask

    task automatic drive(input logic [6:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] wreg);
        valid_i = 1'b1; ctrl_signal_i = ctrl; retAlu_i = addr; wdata_i = wd; WriReg_i = wreg;
    endtask

    task automatic run_op(input string tag, input logic [6:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] wreg, input int lat,
                          input logic [31:0] rdata, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic flush_hold);
        exp_t e;
        drive(ctrl, addr, wd, wreg);
        e.ctrl = ctrl; e.rd = exp_rd; e.alu = addr; e.wreg = wreg;
        sb_q.push_back(e);
        @(posedge clk_i); #1;
        valid_i = flush_hold; flush_i = flush_hold;
        if (!(ctrl[3] | ctrl[2])) begin
            @(negedge clk_i);
            check({tag, "_stall"}, 32'(stall_o), 32'd0);
            check({tag, "_req"}, 32'(dmem_req_o), 32'd0);
            compare_out(tag);
            @(posedge clk_i); #1;
        end else begin
            for (int c = 0; c <= lat; c++) begin
                dmem_ack_i   = (c == lat);
                dmem_rdata_i = (c == lat) ? rdata : ~rdata;
                @(negedge clk_i);
                check({tag, "_stall"}, 32'(stall_o), 32'(c < lat));
                check({tag, "_req"}, 32'(dmem_req_o), 32'd1);
                check({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
                check({tag, "_we"}, 32'(dmem_we_o), 32'(ctrl[2]));
                if (ctrl[2]) begin
                    check({tag, "_be"}, 32'(dmem_be_o), 32'(exp_be));
                    check({tag, "_wd"}, dmem_wdata_o, exp_wd);
                end
                if (c < lat) check({tag, "_ctrl_stall"}, 32'(ctrl_signal_o), 32'd0);
                else         compare_out(tag);
                @(posedge clk_i); #1;
                dmem_ack_i = 1'b0;
            end
        end
        valid_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic run_misaligned(input string tag, input logic [6:0] ctrl, input logic [31:0] addr);
        drive(ctrl, addr, 32'h5555_5555, 5'd9);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_req"}, 32'(dmem_req_o), 32'd0);
        check({tag, "_mis"}, 32'(misalign_o), 32'd1);
        check({tag, "_ctrl"}, 32'(ctrl_signal_o), 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check({tag, "_mis_end"}, 32'(misalign_o), 32'd0);
        check({tag, "_req_end"}, 32'(dmem_req_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        exp_t        e;
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; dmem_ack_i = 1'b0;
        ctrl_signal_i = 7'd0; retAlu_i = 32'd0; wdata_i = 32'd0; WriReg_i = 5'd0;
        dmem_rdata_i = 32'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_mis",   32'(misalign_o), 32'd0);
        check("rst_req",   32'(dmem_req_o), 32'd0);
        check("rst_we",    32'(dmem_we_o), 32'd0);
        check("rst_be",    32'(dmem_be_o), 32'd0);
        check("rst_addr",  dmem_addr_o, 32'd0);
        check("rst_wd",    dmem_wdata_o, 32'd0);
        check("rst_ctrl",  32'(ctrl_signal_o), 32'd0);
        check("rst_rd",    Readdata_o, 32'd0);
        check("rst_alu",   retAlu_o, 32'd0);
        check("rst_wreg",  32'(WriReg_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        run_op("add", 7'h42, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0);
        run_op("lw",  7'h4B, 32'h0000_0100, 32'd0, 5'd6, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd0, 32'd0, 1'b0);
        run_op("lb",  7'h0B, 32'h0000_0103, 32'd0, 5'd7, 1, 32'h80FF_FF7F, 32'hFFFF_FF80, 4'd0, 32'd0, 1'b0);
        run_op("lbu", 7'h1B, 32'h0000_0103, 32'd0, 5'd8, 0, 32'h80FF_FF7F, 32'h0000_0080, 4'd0, 32'd0, 1'b0);
        run_op("lh",  7'h2B, 32'h0000_0102, 32'd0, 5'd9, 2, 32'h80FF_FF7F, 32'hFFFF_80FF, 4'd0, 32'd0, 1'b0);
        run_op("sb",  7'h04, 32'h0000_0002, 32'h0000_00AB, 5'd0, 1, 32'd0, 32'd0, 4'b0100, 32'hABAB_ABAB, 1'b0);
        run_op("sh",  7'h24, 32'h0000_0002, 32'h1234_CDEF, 5'd0, 0, 32'd0, 32'd0, 4'b1100, 32'hCDEF_CDEF, 1'b0);
        run_op("sw",  7'h44, 32'h0000_0010, 32'h1122_3344, 5'd0, 0, 32'd0, 32'd0, 4'b1111, 32'h1122_3344, 1'b0);
        run_op("rw_st", 7'h4C, 32'h0000_0020, 32'hCAFE_F00D, 5'd0, 1, 32'd0, 32'd0, 4'b1111, 32'hCAFE_F00D, 1'b0);

        // Every byte lane for signed byte loads and byte stores
        rd = 32'h8001_7F80;
        for (int i = 0; i < 4; i++) begin
            b = rd[8*i +: 8];
            run_op("lb_lane", 7'h0B, 32'h0000_0040 + 32'(i), 32'd0, 5'd3, i, rd,
                   {{24{b[7]}}, b}, 4'd0, 32'd0, 1'b0);
            run_op("sb_lane", 7'h04, 32'h0000_0050 + 32'(i), 32'h0000_0000 + 32'(i + 16), 5'd0, 0, 32'd0,
                   32'd0, 4'(1 << i), {4{8'(i + 16)}}, 1'b0);
        end

        // Flush held during a stall must not disturb the outstanding load
        run_op("lw_flush", 7'h4B, 32'h0000_0180, 32'd0, 5'd11, 3, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'd0, 32'd0, 1'b1);
        @(negedge clk_i);
        check("flush_bubble", 32'(ctrl_signal_o), 32'd0);
        check("flush_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk_i); #1;

        run_misaligned("lw_mis", 7'h4B, 32'h0000_0101);
        run_misaligned("sh_mis", 7'h24, 32'h0000_0001);

        // Back-to-back zero-wait loads
        drive(7'h4B, 32'h0000_0300, 32'd0, 5'd7);
        e.ctrl = 7'h4B; e.rd = 32'hA5A5_0001; e.alu = 32'h0000_0300; e.wreg = 5'd7; sb_q.push_back(e);
        @(posedge clk_i); #1;
        drive(7'h4B, 32'h0000_0304, 32'd0, 5'd8);
        e.rd = 32'h5A5A_0002; e.alu = 32'h0000_0304; e.wreg = 5'd8; sb_q.push_back(e);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hA5A5_0001;
        @(negedge clk_i);
        check("b2b_stall0", 32'(stall_o), 32'd0);
        compare_out("b2b_a");
        @(posedge clk_i); #1;
        valid_i = 1'b0; dmem_rdata_i = 32'h5A5A_0002;
        @(negedge clk_i);
        check("b2b_req", 32'(dmem_req_o), 32'd1);
        check("b2b_addr", dmem_addr_o, 32'h0000_0304);
        check("b2b_stall1", 32'(stall_o), 32'd0);
        compare_out("b2b_b");
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("b2b_idle", 32'(dmem_req_o), 32'd0);

        // Reset while waiting abandons the access; a late ack is ignored
        @(posedge clk_i); #1;
        drive(7'h4B, 32'h0000_0200, 32'd0, 5'd12);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("rw_req", 32'(dmem_req_o), 32'd1);
        check("rw_stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        check("rw_req_drop", 32'(dmem_req_o), 32'd0);
        check("rw_stall0", 32'(stall_o), 32'd0);
        check("rw_ctrl", 32'(ctrl_signal_o), 32'd0);
        check("rw_rd", Readdata_o, 32'd0);
        check("rw_alu", retAlu_o, 32'd0);
        check("rw_wreg", 32'(WriReg_o), 32'd0);
        @(posedge clk_i); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk_i);
        check("rw_req_after", 32'(dmem_req_o), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

EX/MEM pipeline register combined with the data-memory access engine of the pipelined MIPS core. It sits between the execute stage and the MEM/WB register:
- Latches the execute-stage results.
- Issues byte/half/word loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Presents formatted results (or bubbles) to MEM/WB every cycle.

## Interface
Parameters: none.
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  EX stage holds a real instruction
- ctrl_signal_i  input  7  [6:5] size (00 byte, 01 half, 10 word, 11 word), [4] unsigned load, [3] MemRead, [2] MemWrite, [1] RegWrite, [0] MemtoReg
- retAlu_i  input  32  ALU result / effective address
- wdata_i  input  32  store data (rt value)
- WriReg_i  input  5  destination register
- flush_i  input  1  replace the incoming instruction with a bubble
- stall_o  output  1  freeze PC, IF/ID, ID/EX and this stage's input capture
- misalign_o  output  1  one-cycle pulse: latched access was misaligned and was killed
- dmem_req_o  output  1  memory request, held until ack
- dmem_we_o  output  1  1 = store
- dmem_addr_o  output  32  {retAlu[31:2], 2'b00}
- dmem_be_o  output  4  byte enables, bit n = byte lane n (little-endian)
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_ack_i  input  1  access complete; rdata valid this cycle for loads
- dmem_rdata_i  input  32  read word
- ctrl_signal_o  output  7  to MEM/WB; all zero when a bubble
- Readdata_o  output  32  formatted load data; 0 for non-loads
- retAlu_o  output  32  latched ALU result
- WriReg_o  output  5  latched destination

## Operation
- Entry register holds valid, ctrl, retAlu, wdata, WriReg. It loads on every rising edge where stall_o=0.
  - Loads a bubble (valid=0, ctrl=0) when valid_i=0 or flush_i=1.
- Memory op = valid & (MemRead | MemWrite). MemRead and MemWrite both set: treated as a store.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. Detected combinationally from the input at capture time.
  - A misaligned op is latched as a bubble, issues no request, and asserts misalign_o for the following cycle.
- FSM, two states:
  - IDLE: no access outstanding. On capture of an aligned memory op, go to WAIT.
  - WAIT: dmem_req_o=1, with addr/we/be/wdata stable from the entry.
  - On dmem_ack_i=1 in WAIT: return to IDLE.
  - On capture of another memory op on the same edge as the ack: remain in WAIT, now serving the new entry.
- dmem_req_o = (state==WAIT). dmem_ack_i outside WAIT is ignored.
- stall_o = WAIT & ~dmem_ack_i.
- Byte enables and write data:
  - sb: be = 0001<<addr[1:0], wdata = byte replicated ×4.
  - sh: be = addr[1] ? 1100 : 0011, wdata = half replicated ×2.
  - sw: be = 1111, wdata unchanged.
- Load format, using the lane selected by addr, sign-extended unless bit [4] is set:
  - Readdata_o = {24{s},b} for bytes.
  - Readdata_o = {16{s},h} for halves.
  - Readdata_o = the full word for words.
- Outputs to MEM/WB are combinational from the entry (and from dmem_rdata_i for loads):
  - While stall_o=1, ctrl_signal_o=0, so MEM/WB captures a bubble.
  - Otherwise ctrl_signal_o = entry ctrl.

## Timing
- Reset values:
  - State IDLE, entry cleared (valid=0, all fields 0).
  - stall_o=0, misalign_o=0, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0.
  - ctrl_signal_o=0, Readdata_o=0, retAlu_o=0, WriReg_o=0.
- Non-memory op captured at edge N: outputs valid during cycle N, consumed by MEM/WB at edge N+1; zero stall.
- Memory op captured at edge N, ack in cycle N+k (k≥0):
  - stall_o=1 for cycles N..N+k-1.
  - Result is presented in cycle N+k and MEM/WB captures it at edge N+k+1.
  - Zero-wait memory (ack in same cycle as req) gives no stall.
- Back-to-back memory ops with zero-wait acks sustain one access per cycle.
- flush_i while stall_o=1 has no effect; the outstanding access always completes. Upstream holds its flush request.
- Reset asserted in WAIT:
  - dmem_req_o drops after that edge and the access is abandoned.
  - An ack arriving after reset is ignored.

## Test plan
- add result 0x1234, WriReg 5, ack unused -> ctrl_signal_o=ctrl, retAlu_o=0x1234 in cycle after capture, stall_o never high.
- lw addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall_o high 3 cycles, ctrl_signal_o=0 during stall, then Readdata_o=0xDEADBEEF with ctrl restored.
- lb addr 0x103 with rdata 0x80FF_FF7F -> Readdata_o=0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x102 -> 0xFFFF80FF.
- sb data 0xAB at addr 0x2 -> dmem_be_o=0100, dmem_wdata_o=0xABABABAB, dmem_we_o=1; sh at 0x2 -> be=1100.
- lw at addr 0x101 -> no dmem_req_o, misalign_o pulse 1 cycle, ctrl_signal_o=0.
- rst_i during WAIT with ack arriving 1 cycle later -> req drops, ack ignored, all outputs zero; flush_i during stall -> no change until ack.
